bullet_collider: RTL and testbench

Per-frame collision and damage stage downstream of the bullet store. On each frame tick it walks every bullet slot through the store's collision read port, and tests each rendered bullet's box against the player heart box. It then reports a hit mask back to the store and updates the player HP counter. The HP counter feeds the HUD and the game-over logic.

---
 rtl/bullet_collider.sv | 144 ++++++++++++++
 tb/tb_bullet_collider.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bullet_collider.sv
// Per-frame bullet vs. heart collision scan with HP bookkeeping.
// Optional green-bullet healing is enabled by defining BULLET_COLLIDER_HEAL_EN.
module bullet_collider #(
  parameter int NUM_BULLETS = 3,
  parameter int HP_INIT     = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [15:0]            player_pos,
  input  logic [15:0]            player_size,
  input  logic                   player_moving,
  input  logic [15:0]            bullet_pos,
  input  logic [15:0]            bullet_size,
  input  logic [1:0]             bullet_color,
  input  logic                   bullet_render,
  output logic [2:0]             bullet_index,
  output logic [NUM_BULLETS-1:0] hit_mask,
  output logic [7:0]             hp,
  output logic                   busy,
  output logic                   done,
  output logic                   dead
);

  typedef enum logic [2:0] {IDLE, FETCH, CHECK, APPLY, DONE} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic [NUM_BULLETS-1:0] scratch_q, scratch_d;
  logic [NUM_BULLETS-1:0] hit_mask_q, hit_mask_d;
  logic [7:0]             hp_q, hp_d;
  logic [5:0]             dmg_q, dmg_d;
  logic [3:0]             heal_q, heal_d;
  logic                   done_q, done_d;

  logic [8:0]        px_end, py_end, bx_end, by_end;
  logic              hit;
  logic signed [9:0] hp_calc;

  assign px_end = {1'b0, player_pos[15:8]} + {1'b0, player_size[15:8]};
  assign py_end = {1'b0, player_pos[7:0]}  + {1'b0, player_size[7:0]};
  assign bx_end = {1'b0, bullet_pos[15:8]} + {1'b0, bullet_size[15:8]};
  assign by_end = {1'b0, bullet_pos[7:0]}  + {1'b0, bullet_size[7:0]};

  // Strict overlap test: boxes that only share an edge do not collide.
  assign hit = bullet_render
             && ({1'b0, bullet_pos[15:8]} < px_end) && ({1'b0, player_pos[15:8]} < bx_end)
             && ({1'b0, bullet_pos[7:0]}  < py_end) && ({1'b0, player_pos[7:0]}  < by_end);

  assign hp_calc = 10'(hp_q) - 10'(dmg_q) + 10'(heal_q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    scratch_d  = scratch_q;
    hit_mask_d = hit_mask_q;
    hp_d       = hp_q;
    dmg_d      = dmg_q;
    heal_d     = heal_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // done_q high means the previous scan is still reporting; treat as busy.
        if (start && !dead && !done_q) begin
          scratch_d = '0;
          dmg_d     = '0;
          heal_d    = '0;
          idx_d     = '0;
          state_d   = FETCH;
        end
      end
      FETCH: state_d = CHECK;
      CHECK: begin
        if (hit) begin
          scratch_d = scratch_q | (NUM_BULLETS'(1) << idx_q);
          unique case (bullet_color)
            2'b01: begin
`ifdef BULLET_COLLIDER_HEAL_EN
              heal_d = heal_q + 4'd1;
`else
              dmg_d = dmg_q + 6'd1;
`endif
            end
            2'b10:   dmg_d = dmg_q + (player_moving ? 6'd1 : 6'd0);
            default: dmg_d = dmg_q + 6'd2;
          endcase
        end
        if (idx_q == 3'(NUM_BULLETS - 1)) begin
          state_d = APPLY;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = FETCH;
        end
      end
      APPLY: begin
        if (hp_calc < 10'sd0)
          hp_d = 8'd0;
        else if (hp_calc > $signed(10'(HP_INIT)))
          hp_d = 8'(HP_INIT);
        else
          hp_d = hp_calc[7:0];
        hit_mask_d = scratch_q;
        idx_d      = '0;
        state_d    = DONE;
      end
      DONE: begin
        // Registered so done rises one edge after hp/hit_mask update.
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      scratch_q  <= '0;
      hit_mask_q <= '0;
      hp_q       <= 8'(HP_INIT);
      dmg_q      <= '0;
      heal_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      scratch_q  <= scratch_d;
      hit_mask_q <= hit_mask_d;
      hp_q       <= hp_d;
      dmg_q      <= dmg_d;
      heal_q     <= heal_d;
      done_q     <= done_d;
    end
  end

  assign bullet_index = idx_q;
  assign hit_mask     = hit_mask_q;
  assign hp           = hp_q;
  assign done         = done_q;
  assign busy         = (state_q != IDLE) || done_q;
  assign dead         = (hp_q == 8'd0);

endmodule

// File: tb/tb_bullet_collider.sv
// Randomized and directed bench for bullet_collider against a box-overlap reference model.
module tb_bullet_collider;
  localparam int NB  = 3;
  localparam int HPI = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   player_pos = '0, player_size = '0;
  logic          player_moving = 1'b0;
  logic [15:0]   bullet_pos, bullet_size;
  logic [1:0]    bullet_color;
  logic          bullet_render;
  logic [2:0]    bullet_index;
  logic [NB-1:0] hit_mask;
  logic [7:0]    hp;
  logic          busy, done, dead;

  logic [15:0] s_pos [NB];
  logic [15:0] s_size[NB];
  logic [1:0]  s_col [NB];
  logic        s_ren [NB];

  int errors = 0;
  int checks = 0;
  int model_hp = HPI;
  int exp_mask;

  bullet_collider #(.NUM_BULLETS(NB), .HP_INIT(HPI)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .player_pos(player_pos), .player_size(player_size), .player_moving(player_moving),
    .bullet_pos(bullet_pos), .bullet_size(bullet_size), .bullet_color(bullet_color),
    .bullet_render(bullet_render), .bullet_index(bullet_index), .hit_mask(hit_mask),
    .hp(hp), .busy(busy), .done(done), .dead(dead)
  );

  always #5 clk = ~clk;

  // Combinational slot store.
  always_comb begin
    bullet_pos = '0; bullet_size = '0; bullet_color = '0; bullet_render = 1'b0;
    if (int'(bullet_index) < NB) begin
      bullet_pos    = s_pos[int'(bullet_index)];
      bullet_size   = s_size[int'(bullet_index)];
      bullet_color  = s_col[int'(bullet_index)];
      bullet_render = s_ren[int'(bullet_index)];
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_player(input int x, input int y, input int w, input int h, input bit mov);
    player_pos = {8'(x), 8'(y)}; player_size = {8'(w), 8'(h)}; player_moving = mov;
  endtask

  task automatic set_slot(input int i, input int x, input int y, input int w, input int h,
                          input int col, input bit ren);
    s_pos[i] = {8'(x), 8'(y)}; s_size[i] = {8'(w), 8'(h)}; s_col[i] = 2'(col); s_ren[i] = ren;
  endtask

  // Reference: plain integer box overlap and per-colour damage/heal, then clamp.
  task automatic model_scan();
    int dmg, heal, px, py, pw, ph, bx, by, bw, bh;
    dmg = 0; heal = 0; exp_mask = 0;
    px = int'(player_pos[15:8]); py = int'(player_pos[7:0]);
    pw = int'(player_size[15:8]); ph = int'(player_size[7:0]);
    for (int i = 0; i < NB; i++) begin
      bx = int'(s_pos[i][15:8]); by = int'(s_pos[i][7:0]);
      bw = int'(s_size[i][15:8]); bh = int'(s_size[i][7:0]);
      if (s_ren[i] && bx < px + pw && px < bx + bw && by < py + ph && py < by + bh) begin
        exp_mask |= (1 << i);
        if (s_col[i] == 2'b01) begin
`ifdef BULLET_COLLIDER_HEAL_EN
          heal += 1;
`else
          dmg += 1;
`endif
        end else if (s_col[i] == 2'b10) dmg += player_moving ? 1 : 0;
        else dmg += 2;
      end
    end
    model_hp = model_hp - dmg + heal;
    if (model_hp < 0) model_hp = 0;
    if (model_hp > HPI) model_hp = HPI;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_hp = HPI;
  endtask

  task automatic run_scan(input string tag, input bit poke);
    int done_cnt, busy_low;
    done_cnt = 0; busy_low = 0;
    model_scan();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #1;
      if (poke && e == 3) start = 1'b1;
      if (poke && e == 4) start = 1'b0;
      if (done) done_cnt++;
      if (e <= 8 && !busy) busy_low++;
      if (e == 2) check_eq({tag, "_index1"}, int'(bullet_index), 1);
      if (e == 6) check_eq({tag, "_early_done"}, done_cnt, 0);
      if (e == 7) begin
        check_eq({tag, "_mask"}, int'(hit_mask), exp_mask);
        check_eq({tag, "_hp"}, int'(hp), model_hp);
        check_eq({tag, "_done_lo"}, int'(done), 0);
      end
      if (e == 8) check_eq({tag, "_done_hi"}, int'(done), 1);
    end
    check_eq({tag, "_done_cnt"}, done_cnt, 1);
    check_eq({tag, "_busy_span"}, busy_low, 0);
    check_eq({tag, "_busy_end"}, int'(busy), 0);
    check_eq({tag, "_dead"}, int'(dead), (model_hp == 0) ? 1 : 0);
    check_eq({tag, "_index0"}, int'(bullet_index), 0);
    $display("scan %s mask=%0d hp=%0d exp_mask=%0d exp_hp=%0d", tag, hit_mask, hp, exp_mask, model_hp);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < NB; i++) set_slot(i, 0, 0, 0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_hp", int'(hp), HPI);
    check_eq("rst_mask", int'(hit_mask), 0);
    check_eq("rst_index", int'(bullet_index), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_dead", int'(dead), 0);

    set_player(8'h80, 8'h80, 8'h10, 8'h10, 1'b0);
    set_slot(0, 8'h88, 8'h88, 8'h10, 8'h10, 0, 1'b1);
    run_scan("basic", 1'b0);
    check_eq("basic_const", int'(hp), 18);

    set_slot(0, 8'h90, 8'h88, 8'h10, 8'h10, 0, 1'b1);
    run_scan("edge", 1'b0);
    check_eq("edge_const", int'(hit_mask), 0);

    set_slot(0, 8'h88, 8'h88, 8'h10, 8'h10, 2, 1'b1);
    run_scan("blue_still", 1'b0);
    check_eq("blue_still_const", int'(hp), 18);
    player_moving = 1'b1;
    run_scan("blue_move", 1'b0);
    check_eq("blue_move_const", int'(hp), 17);

    set_slot(0, 8'h88, 8'h88, 8'h10, 8'h10, 0, 1'b1);
    run_scan("poke", 1'b1);

    // Reset asserted while the first slot is in CHECK.
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_hp", int'(hp), HPI);
    check_eq("mid_rst_mask", int'(hit_mask), 0);
    check_eq("mid_rst_busy", int'(busy), 0);
    check_eq("mid_rst_done", int'(done), 0);
    check_eq("mid_rst_index", int'(bullet_index), 0);
    @(negedge clk); rst_n = 1'b1;
    model_hp = HPI;

    set_slot(0, 8'h88, 8'h88, 8'h10, 8'h10, 1, 1'b1);
    run_scan("green", 1'b0);
`ifdef BULLET_COLLIDER_HEAL_EN
    check_eq("green_const", int'(hp), 20);
`else
    check_eq("green_const", int'(hp), 19);
`endif

    // Drive HP to 1, then a white hit kills.
    do_reset();
    player_moving = 1'b1;
    for (int i = 0; i < NB; i++) set_slot(i, 8'h84, 8'h84, 8'h08, 8'h08, 0, 1'b1);
    for (int k = 0; k < 3; k++) run_scan("drain", 1'b0);
    for (int i = 1; i < NB; i++) s_ren[i] = 1'b0;
    s_col[0] = 2'b10;
    run_scan("to_one", 1'b0);
    check_eq("to_one_const", int'(hp), 1);
    s_col[0] = 2'b00;
    run_scan("kill", 1'b0);
    check_eq("kill_dead", int'(dead), 1);
    seen = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    check_eq("dead_ignore", seen, 0);
    $display("scan dead_start busy_or_done_cycles=%0d", seen);

    do_reset();
    for (int n = 0; n < 40; n++) begin
      int px, py;
      if (model_hp == 0) do_reset();
      px = $urandom_range(20, 200); py = $urandom_range(20, 200);
      set_player(px, py, $urandom_range(1, 40), $urandom_range(1, 40), 1'($urandom_range(0, 1)));
      for (int i = 0; i < NB; i++)
        set_slot(i, px + $urandom_range(0, 60) - 30, py + $urandom_range(0, 60) - 30,
                 $urandom_range(1, 40), $urandom_range(1, 40), $urandom_range(0, 3),
                 $urandom_range(0, 3) != 0);
      run_scan("rand", 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
